// File: rtl/instr_split_queue.sv
// instr_split_queue: first-word-fall-through instruction queue. The head
// entry is split combinationally into MIPS instruction fields.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   flush          synchronous discard of all entries (reset wins over it)
//   in_valid/in_ready/in_instr/in_pc      producer handshake and payload
//   out_valid/out_ready/out_pc            consumer handshake and head PC
//   OP rs rt rd shamt func offset im26    raw fields of the head instruction
//   imm_sext/imm_zext                     offset widened to 32 bits
//   itype          00 R, 01 I, 10 J
//   count          number of occupied entries
module instr_split_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [5:0]               OP,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               func,
  output logic [15:0]              offset,
  output logic [25:0]              im26,
  output logic [31:0]              imm_sext,
  output logic [31:0]              imm_zext,
  output logic [1:0]               itype,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    wr_ptr, rd_ptr;
  logic               enq, deq;
  entry_t             head;

  // No bypass in either direction: readiness depends only on stored count.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Storage is not reset; stale contents are hidden by out_valid gating.
  always_ff @(posedge clk) begin
    if (enq && !reset) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
  end

  assign head     = out_valid ? mem[rd_ptr] : '0;
  assign out_pc   = head.pc;
  assign OP       = head.instr[31:26];
  assign rs       = head.instr[25:21];
  assign rt       = head.instr[20:16];
  assign rd       = head.instr[15:11];
  assign shamt    = head.instr[10:6];
  assign func     = head.instr[5:0];
  assign offset   = head.instr[15:0];
  assign im26     = head.instr[25:0];
  assign imm_sext = {{16{head.instr[15]}}, head.instr[15:0]};
  assign imm_zext = {16'h0000, head.instr[15:0]};

  always_comb begin
    itype = 2'b00;
    if (out_valid) begin
      if (head.instr[31:26] == 6'd0)
        itype = 2'b00;
      else if (head.instr[31:26] == 6'd2 || head.instr[31:26] == 6'd3)
        itype = 2'b10;
      else
        itype = 2'b01;
    end
  end

endmodule

// File: tb/tb_instr_split_queue.sv
module tb_instr_split_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [5:0]    OP, func;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   offset;
  logic [25:0]   im26;
  logic [31:0]   imm_sext, imm_zext;
  logic [1:0]    itype;
  logic [CW-1:0] count;

  instr_split_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .OP(OP), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .offset(offset), .im26(im26), .imm_sext(imm_sext), .imm_zext(imm_zext),
    .itype(itype), .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] q[$];   // reference queue of {instr, pc}

  typedef struct {
    logic [31:0] instr, pc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [1:0]  it;
    logic [15:0] off;
    logic [31:0] sext, zext;
    logic [25:0] im;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [176:0] exp_bundle(logic v, logic [31:0] ins, logic [31:0] pc,
                                              int cnt, logic rdy);
    int op;
    logic [1:0]  it;
    logic [31:0] s, z;
    if (!v) begin ins = 0; pc = 0; end
    op = int'(ins >> 26);
    it = !v ? 2'd0 : (op == 0) ? 2'd0 : (op == 2 || op == 3) ? 2'd2 : 2'd1;
    z  = ins % 65536;
    s  = (z >= 32768) ? z + 32'hFFFF0000 : z;
    return {v, rdy, CW'(cnt), pc, 6'(ins >> 26), 5'((ins >> 21) % 32), 5'((ins >> 16) % 32),
            5'((ins >> 11) % 32), 5'((ins >> 6) % 32), 6'(ins % 64), 16'(z),
            26'(ins % (1 << 26)), s, z, it};
  endfunction

  function automatic logic [176:0] act_bundle();
    return {out_valid, in_ready, count, out_pc, OP, rs, rt, rd, shamt, func, offset,
            im26, imm_sext, imm_zext, itype};
  endfunction

  task automatic chk(string name, logic [176:0] act, logic [176:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic v;
    logic [63:0] e;
    v = (q.size() > 0);
    e = v ? q[0] : 64'd0;
    chk(tag, act_bundle(), exp_bundle(v, e[63:32], e[31:0], q.size(), q.size() < DEPTH));
  endtask

  // One clock: drive at negedge, check pre-edge state, advance model at posedge.
  task automatic tick(string tag, logic v, logic [31:0] ins, logic [31:0] pc,
                      logic ordy, logic fl, logic rst);
    logic e_enq, e_deq;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; reset = rst;
    #1 check_model(tag);
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      e_enq = v && (q.size() < DEPTH);
      e_deq = (q.size() > 0) && ordy;
      if (e_deq) void'(q.pop_front());
      if (e_enq) q.push_back({ins, pc});
    end
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h012A4020, 32'h3000, 6'h00, 6'h20, 5'd9, 5'd10, 5'd8, 5'd0, 2'b00,
                16'h4020, 32'h00004020, 32'h00004020, 26'h12A4020};
    vecs[1] = '{32'h8D09FFFC, 32'h3004, 6'h23, 6'h3C, 5'd8, 5'd9, 5'd31, 5'd31, 2'b01,
                16'hFFFC, 32'hFFFFFFFC, 32'h0000FFFC, 26'h109FFFC};
    vecs[2] = '{32'h0C000C00, 32'h3008, 6'h03, 6'h00, 5'd0, 5'd0, 5'd1, 5'd16, 2'b10,
                16'h0C00, 32'h00000C00, 32'h00000C00, 26'h0000C00};
    vecs[3] = '{32'h08000010, 32'h300C, 6'h02, 6'h10, 5'd0, 5'd0, 5'd0, 5'd0, 2'b10,
                16'h0010, 32'h00000010, 32'h00000010, 26'h0000010};
    vecs[4] = '{32'h35088001, 32'h3010, 6'h0D, 6'h01, 5'd8, 5'd8, 5'd16, 5'd0, 2'b01,
                16'h8001, 32'hFFFF8001, 32'h00008001, 26'h1088001};

    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", act_bundle(), {1'b0, 1'b1, 175'd0});

    // Table: each word into an empty queue, visible one cycle later, then drained.
    foreach (vecs[i]) begin
      tick("tbl_enq", 1, vecs[i].instr, vecs[i].pc, 0, 0, 0);
      chk($sformatf("tbl_fields_%0d", i),
          {out_valid, count, out_pc, OP, rs, rt, rd, shamt, func, itype, offset,
           imm_sext, imm_zext, im26},
          {1'b1, CW'(1), vecs[i].pc, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
           vecs[i].sh, vecs[i].fn, vecs[i].it, vecs[i].off, vecs[i].sext, vecs[i].zext,
           vecs[i].im});
      tick("tbl_deq", 0, 0, 0, 1, 0, 0);
    end

    // Fill to DEPTH with out_ready low; the fifth word must be refused.
    for (int i = 0; i < 5; i++) tick("fill", 1, 32'h1000 + i, 32'h200 + 4 * i, 0, 0, 0);
    chk("full_state", {in_ready, count, in_instr}, {1'b0, CW'(DEPTH), 32'h1004});
    chk("full_head", {out_valid, func, out_pc}, {1'b1, 6'h00, 32'h200});
    tick("full_deq", 1, 32'h1004, 32'h210, 1, 0, 0);
    chk("after_full_deq", {in_ready, count, out_pc}, {1'b1, CW'(3), 32'h204});
    for (int i = 0; i < 3; i++) tick("drain", 0, 0, 0, 1, 0, 0);
    chk("drained", {out_valid, count}, {1'b0, CW'(0)});

    // Flush with count=3 while offering and consuming: all cleared, word dropped.
    for (int i = 0; i < 3; i++) tick("pre_flush", 1, 32'h2000 + i, 32'h400 + i, 0, 0, 0);
    tick("flush", 1, 32'hDEADBEEF, 32'h500, 1, 1, 0);
    chk("after_flush", act_bundle(), {1'b0, 1'b1, 175'd0});
    tick("post_flush", 0, 0, 0, 0, 0, 0);
    chk("flush_dropped", {out_valid, count}, {1'b0, CW'(0)});

    // Reset with count=2, then a fresh word must be the first delivered.
    for (int i = 0; i < 2; i++) tick("pre_rst", 1, 32'h3000 + i, 32'h600 + i, 0, 0, 0);
    tick("rst", 1, 32'h3FFF, 32'h6FF, 1, 1, 1);
    chk("after_rst", {count, in_ready, out_valid}, {CW'(0), 1'b1, 1'b0});
    tick("rst_enq", 1, 32'h8D09FFFC, 32'h700, 0, 0, 0);
    chk("rst_first", {out_valid, out_pc, OP, itype}, {1'b1, 32'h700, 6'h23, 2'b01});
    tick("rst_clr", 0, 0, 0, 1, 0, 0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++)
      tick("rand", ($urandom % 4) != 0, $urandom, $urandom, $urandom % 2,
           ($urandom % 40) == 0, ($urandom % 90) == 0);
    tick("rand_end", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_split_queue.md
INSTR_SPLIT_QUEUE -- requirements
Module: instr_split_queue

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter PC_W, default 32, giving the width of the PC carried with each instruction.

Interface
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous queue discard.
REQ-007 in_valid  in  1  producer holds a valid instruction.
REQ-008 in_ready  out  1  queue accepts an instruction this cycle.
REQ-009 in_instr  in  32  raw MIPS instruction word.
REQ-010 in_pc  in  PC_W  address of in_instr.
REQ-011 out_valid  out  1  head entry is valid.
REQ-012 out_ready  in  1  consumer takes the head entry this cycle.
REQ-013 out_pc  out  PC_W  PC of the head entry.
REQ-014 OP  out  6  head instr[31:26].
REQ-015 rs, rt, rd  out  5 each  head instr[25:21], instr[20:16], instr[15:11].
REQ-016 shamt  out  5  head instr[10:6].
REQ-017 func  out  6  head instr[5:0].
REQ-018 offset  out  16  head instr[15:0].
REQ-019 im26  out  26  head instr[25:0].
REQ-020 imm_sext / imm_zext  out  32 each  offset sign-extended / zero-extended to 32 bits.
REQ-021 itype  out  2  instruction format: 00 R (OP==0), 10 J (OP==2 or OP==3), 01 I (any other OP); value 11 is never driven.
REQ-022 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-023 An enqueue SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0; it writes in_instr and in_pc at wr_ptr and increments wr_ptr modulo DEPTH.
REQ-024 A dequeue SHALL occur on a rising edge where out_valid=1, out_ready=1 and flush=0; it increments rd_ptr modulo DEPTH.
REQ-025 in_ready SHALL be 1 when count<DEPTH and 0 when count==DEPTH; there is no full-queue bypass, so a simultaneous dequeue does not allow an enqueue while full.
REQ-026 out_valid SHALL be 1 when count>0.
REQ-027 There is no empty-queue bypass: an instruction enqueued into an empty queue SHALL appear at the outputs, with out_valid=1, in the cycle after the enqueue edge (latency 1).
REQ-028 The queue SHALL be first-word-fall-through: all field outputs, out_pc and itype are decoded combinationally from the head entry.
REQ-029 When out_valid=0, every field output, out_pc, imm_sext, imm_zext and itype SHALL be driven to 0.
REQ-030 A simultaneous enqueue and dequeue with 0<count<DEPTH SHALL leave count unchanged.
REQ-031 On an enqueue only, count SHALL increase by 1; on a dequeue only, it SHALL decrease by 1.
REQ-032 Entries SHALL be delivered in strict FIFO order across pointer wrap-around.
REQ-033 flush=1 SHALL set count, wr_ptr and rd_ptr to 0 on the same edge and has priority over any enqueue or dequeue in that cycle; the offered instruction is dropped.
REQ-034 Entry storage contents are don't-care after flush or reset; only the pointers and count are cleared.
REQ-035 The output fields SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-036 reset=1 at a rising edge SHALL set count=0, wr_ptr=0 and rd_ptr=0, giving out_valid=0, in_ready=1 and all field outputs 0.
REQ-037 reset SHALL take priority over flush, enqueue and dequeue.
REQ-038 A reset asserted mid-operation SHALL discard all queued entries.

Verification
REQ-039 Scenario: enqueue 0x012A4020 (add $8,$9,$10) at PC 0x3000 into an empty queue -> next cycle out_valid=1, OP=0, rs=9, rt=10, rd=8, shamt=0, func=0x20, itype=00, out_pc=0x3000.
REQ-040 Scenario: enqueue 0x8D09FFFC (lw $9,-4($8)) -> itype=01, offset=0xFFFC, imm_sext=0xFFFFFFFC, imm_zext=0x0000FFFC; enqueue 0x0C000C00 (jal) -> itype=10, im26=0x0000C00.
REQ-041 Scenario: DEPTH=4, out_ready=0, hold in_valid=1 -> count reaches 4, in_ready=0; the fifth word is not accepted; assert out_ready=1 for one cycle -> count=3 and in_ready=1.
REQ-042 Scenario: stream 10 instructions with random out_ready -> output order matches input order through pointer wrap, with no loss or duplication.
REQ-043 Scenario: count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, all outputs 0, and the offered word is dropped.
REQ-044 Scenario: count=2, assert reset -> next cycle count=0, in_ready=1, out_valid=0; an enqueue in the following cycle is delivered first.
